// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage ARM pipeline: EX operand forwarding,
// load-use and flag-use stalls, branch flush, and multi-cycle data-memory freeze.

module pipe_hazard_fwd_sel #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output logic [1:0]       sel
);
  localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

  // The younger producer (EX/MEM) holds the newer value, so it wins over MEM/WB.
  always_comb begin
    sel = 2'b00;
    if (mem_regwrite && mem_rd == src && mem_rd != XZR)
      sel = 2'b01;
    else if (wb_regwrite && wb_rd == src && wb_rd != XZR)
      sel = 2'b10;
  end
endmodule

module pipe_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int MEM_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_condbr,
  input  logic             id_br_taken,
  input  logic [REG_W-1:0] ex_rn,
  input  logic [REG_W-1:0] ex_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_setflags,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_access,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int               NUM_OPS = 2;
  localparam int               WCW     = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam bit               MULTI   = (MEM_LAT > 1);
  localparam logic [REG_W-1:0] XZR     = REG_W'(ZERO_REG);
  localparam logic [WCW-1:0]   WAIT_LD = WCW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic if_id_flush;
    logic freeze;
  } ctrl_t;

  // Operand index 0 is A (rn), 1 is B (rm).
  logic [NUM_OPS-1:0][REG_W-1:0] ex_src, id_src;
  logic [NUM_OPS-1:0]            id_use, id_hit;
  logic [NUM_OPS-1:0][1:0]       fwd_sel;

  assign ex_src = {ex_rm, ex_rn};
  assign id_src = {id_rm, id_rn};
  assign id_use = {id_use_rm, id_use_rn};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    pipe_hazard_fwd_sel #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd (
      .src          (ex_src[i]),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_sel[i])
    );
    assign id_hit[i] = id_use[i] && (id_src[i] == ex_rd);
  end

  logic lu, fu, hz;
  assign lu = ex_memread && ex_regwrite && (ex_rd != XZR) && (|id_hit);
  assign fu = id_condbr && ex_setflags;
  assign hz = lu || fu;

  state_t         state, state_nx;
  logic [WCW-1:0] wait_cnt, wait_cnt_nx;
  logic           frz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // The access that starts in RUN is frozen MEM_LAT-1 cycles and completes on the
  // WAIT cycle where wait_cnt reaches 0, so RUN may immediately accept the next one.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    frz         = 1'b0;
    case (state)
      S_RUN: begin
        if (mem_access && MULTI) begin
          frz         = 1'b1;
          state_nx    = S_WAIT;
          wait_cnt_nx = WAIT_LD;
        end
      end
      S_WAIT: begin
        if (wait_cnt != '0) begin
          frz         = 1'b1;
          wait_cnt_nx = wait_cnt - 1'b1;
        end else begin
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  ctrl_t ctrl;

  // A hazard makes the ID branch decision stale, so the flush only fires when clean.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl = '0;
    end else if (frz) begin
      ctrl.freeze      = 1'b1;
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_stall = 1'b1;
    end else if (hz) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end else if (id_br_taken) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  assign fwd_a        = rst ? 2'b00 : fwd_sel[0];
  assign fwd_b        = rst ? 2'b00 : fwd_sel[1];
  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign if_id_flush  = ctrl.if_id_flush;
  assign freeze       = ctrl.freeze;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (ctrl.pc_stall && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign stall_cycles = rst ? '0 : cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: two instances (MEM_LAT=1/CNT_W=16 and
// MEM_LAT=3/CNT_W=4) share stimulus and are checked every cycle against a rule model.
`timescale 1ns/1ps
module tb_pipe_hazard_unit;
  localparam int LAT_A = 1, CNT_A = 16;
  localparam int LAT_B = 3, CNT_B = 4;

  logic clk = 0, rst = 1;
  logic [4:0] id_rn = 0, id_rm = 0, ex_rn = 0, ex_rm = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
  logic id_use_rn = 0, id_use_rm = 0, id_condbr = 0, id_br_taken = 0;
  logic ex_regwrite = 0, ex_memread = 0, ex_setflags = 0;
  logic mem_regwrite = 0, mem_access = 0, wb_regwrite = 0;

  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic a_pc, a_ifs, a_bub, a_fl, a_fz, b_pc, b_ifs, b_bub, b_fl, b_fz;
  logic [CNT_A-1:0] a_cnt;
  logic [CNT_B-1:0] b_cnt;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_W(5), .ZERO_REG(31), .MEM_LAT(LAT_A), .CNT_W(CNT_A)) u_a (
    .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn),
    .id_use_rm(id_use_rm), .id_condbr(id_condbr), .id_br_taken(id_br_taken),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_setflags(ex_setflags), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_access(mem_access), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .fwd_a(a_fa), .fwd_b(a_fb), .pc_stall(a_pc),
    .if_id_stall(a_ifs), .id_ex_bubble(a_bub), .if_id_flush(a_fl), .freeze(a_fz),
    .stall_cycles(a_cnt));

  pipe_hazard_unit #(.REG_W(5), .ZERO_REG(31), .MEM_LAT(LAT_B), .CNT_W(CNT_B)) u_b (
    .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn),
    .id_use_rm(id_use_rm), .id_condbr(id_condbr), .id_br_taken(id_br_taken),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_setflags(ex_setflags), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_access(mem_access), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .fwd_a(b_fa), .fwd_b(b_fb), .pc_stall(b_pc),
    .if_id_stall(b_ifs), .id_ex_bubble(b_bub), .if_id_flush(b_fl), .freeze(b_fz),
    .stall_cycles(b_cnt));

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fwd_of(input logic [4:0] src);
    if (rst) return 0;
    if (mem_regwrite && mem_rd == src && mem_rd != 31) return 1;
    if (wb_regwrite && wb_rd == src && wb_rd != 31) return 2;
    return 0;
  endfunction

  function automatic bit hazard();
    bit lu;
    lu = ex_memread && ex_regwrite && ex_rd != 31 &&
         ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
    return lu || (id_condbr && ex_setflags);
  endfunction

  // age = cycles the current access has already been held in MEM
  function automatic bit frz_of(input int lat, input int age);
    return !rst && mem_access && lat > 1 && age < lat - 1;
  endfunction

  function automatic int next_age(input int lat, input int age);
    if (rst || !mem_access || lat <= 1) return 0;
    return (age < lat - 1) ? age + 1 : 0;
  endfunction

  int age_a = 0, age_b = 0, mcnt_a = 0, mcnt_b = 0;

  task automatic check_inst(input string tag, input bit fz, input int mcnt,
                            input logic [1:0] fa, input logic [1:0] fb, input logic pc,
                            input logic ifs, input logic bub, input logic fl,
                            input logic fzo, input int cnt, output bit pc_exp);
    bit hz;
    hz = !rst && !fz && hazard();
    pc_exp = !rst && (fz || hz);
    chk({tag, ".fwd_a"}, fa, fwd_of(ex_rn));
    chk({tag, ".fwd_b"}, fb, fwd_of(ex_rm));
    chk({tag, ".pc_stall"}, pc, pc_exp);
    chk({tag, ".if_id_stall"}, ifs, pc_exp);
    chk({tag, ".id_ex_bubble"}, bub, hz);
    chk({tag, ".if_id_flush"}, fl, !rst && !fz && !hz && id_br_taken);
    chk({tag, ".freeze"}, fzo, fz);
    chk({tag, ".stall_cycles"}, cnt, rst ? 0 : mcnt);
  endtask

  always @(negedge clk) begin
    bit pa, pb;
    check_inst("A", frz_of(LAT_A, age_a), mcnt_a, a_fa, a_fb, a_pc, a_ifs, a_bub, a_fl,
               a_fz, int'(a_cnt), pa);
    check_inst("B", frz_of(LAT_B, age_b), mcnt_b, b_fa, b_fb, b_pc, b_ifs, b_bub, b_fl,
               b_fz, int'(b_cnt), pb);
    // inputs are stable until the next posedge, so the model advances here
    age_a  = next_age(LAT_A, age_a);
    age_b  = next_age(LAT_B, age_b);
    mcnt_a = rst ? 0 : (pa && mcnt_a < (1 << CNT_A) - 1) ? mcnt_a + 1 : mcnt_a;
    mcnt_b = rst ? 0 : (pb && mcnt_b < (1 << CNT_B) - 1) ? mcnt_b + 1 : mcnt_b;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ins();
    {id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rn, id_use_rm, id_condbr, id_br_taken} = '0;
    {ex_regwrite, ex_memread, ex_setflags, mem_regwrite, mem_access, wb_regwrite} = '0;
  endtask

  initial begin
    logic [5:0] pat;
    clear_ins();
    rst = 1;
    tick(); tick();
    chk("rst.freeze", a_fz, 0);
    chk("rst.stall_cycles", int'(a_cnt), 0);
    rst = 0;

    // ADD X1 in MEM, SUB reading X1 in EX
    ex_rn = 1; mem_rd = 1; mem_regwrite = 1; #1;
    chk("fwd.mem", a_fa, 2'b01);
    tick();
    wb_rd = 1; wb_regwrite = 1; #1;
    chk("fwd.mem_beats_wb", a_fa, 2'b01);
    tick();
    mem_regwrite = 0; #1;
    chk("fwd.wb", a_fa, 2'b10);
    tick();
    ex_rn = 31; ex_rm = 31; mem_rd = 31; mem_regwrite = 1; wb_rd = 31; #1;
    chk("fwd.xzr_a", a_fa, 2'b00);
    chk("fwd.xzr_b", a_fb, 2'b00);
    tick();
    clear_ins();

    // LDUR X2 in EX, ADD X3,X4,X2 in ID
    ex_rd = 2; ex_regwrite = 1; ex_memread = 1;
    id_rn = 4; id_rm = 2; id_use_rn = 1; id_use_rm = 1; #1;
    chk("lu.pc_stall", a_pc, 1);
    chk("lu.bubble", a_bub, 1);
    tick();
    // bubble in EX, LDUR in MEM, ADD still in ID
    ex_rd = 0; ex_regwrite = 0; ex_memread = 0; mem_rd = 2; mem_regwrite = 1; #1;
    chk("lu.released", a_pc, 0);
    chk("lu.count", int'(a_cnt), 1);
    tick();
    // ADD in EX, LDUR in WB
    clear_ins(); ex_rn = 4; ex_rm = 2; wb_rd = 2; wb_regwrite = 1; #1;
    chk("lu.fwd_b", a_fb, 2'b10);
    tick();
    clear_ins();

    // SUBS in EX, B.EQ taken in ID
    ex_setflags = 1; id_condbr = 1; id_br_taken = 1; #1;
    chk("fu.stall", a_pc, 1);
    chk("fu.no_flush", a_fl, 0);
    tick();
    ex_setflags = 0; #1;
    chk("fu.flush", a_fl, 1);
    chk("fu.unstalled", a_pc, 0);
    tick();
    clear_ins();
    tick();

    // single access then back-to-back accesses on the MEM_LAT=3 instance
    pat = 6'b011011;
    mem_access = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("frz.single", b_fz, int'(pat[i]));
      chk("frz.lat1", a_fz, 0);
      tick();
    end
    mem_access = 0; tick();
    mem_access = 1;
    for (int i = 0; i < 6; i++) begin
      #1; chk("frz.b2b", b_fz, int'(pat[i % 3]));
      tick();
    end
    mem_access = 0; tick();

    // reset while frozen in WAIT
    mem_access = 1; tick();
    #1; chk("frz.wait", b_fz, 1);
    rst = 1; #1;
    chk("rst.mid_wait", b_fz, 0);
    tick();
    rst = 0; mem_access = 0; #1;
    chk("rst.released", b_fz, 0);
    chk("rst.count", int'(b_cnt), 0);
    tick();

    // hold a flag-use hazard for 20 cycles
    ex_setflags = 1; id_condbr = 1;
    repeat (20) tick();
    clear_ins(); #1;
    chk("sat.cnt16", int'(a_cnt), 20);
    chk("sat.cnt4", int'(b_cnt), 15);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
